// File: rtl/clk_div_pkg.sv
// Shared definitions for the clk_div_ctrl divided-clock controller.
// Holds the controller state encoding, the default ratio-field width and
// the smallest divide ratio that may be loaded.
package clk_div_pkg;

    localparam int unsigned RATIO_W_DEF = 8;
    localparam int unsigned MIN_RATIO   = 2;

    typedef enum logic [1:0] {
        IDLE,   // no clock generated, new ratio loads directly
        RUN,    // dividing at ratio_active
        PEND,   // new ratio held until the current period wraps
        DRAIN   // run dropped, finishing the current period
    } state_e;

endpackage

// File: rtl/clk_div_core.sv
// clk_div_core: period counter, wrap detection and output phase generation.
//
// Ports:
//   clk_in    - system clock, rising-edge state updates
//   rst       - synchronous active-high reset
//   run_i     - counter runs in the coming cycle (next-state from the FSM)
//   ratio_i   - ratio governing the current period
//   wrap_o    - current cycle is the last of the period (cnt == N-1)
//   clk_out_o - divided clock
//   tick_o    - high in the first cycle of every period
//
// Macro CLK_DIV_CTRL_ODD50_EN: when defined, a falling-edge copy of the high
// phase is ORed in for odd ratios, giving exactly 50% duty.
module clk_div_core
    import clk_div_pkg::*;
#(
    parameter int unsigned RATIO_W = RATIO_W_DEF
) (
    input  logic               clk_in,
    input  logic               rst,
    input  logic               run_i,
    input  logic [RATIO_W-1:0] ratio_i,
    output logic               wrap_o,
    output logic               clk_out_o,
    output logic               tick_o
);

    localparam logic [RATIO_W-1:0] ONE = RATIO_W'(1);

    logic [RATIO_W-1:0] cnt_q, cnt_d;
    logic [RATIO_W-1:0] half;
    logic               run_q;
    logic               phase_q, phase_d;
    logic               tick_q, tick_d;

    assign half   = ratio_i >> 1;
    assign wrap_o = run_q && (cnt_q == ratio_i - ONE);

    always_comb begin
        cnt_d   = '0;
        phase_d = 1'b0;
        tick_d  = 1'b0;
        if (run_i) begin
            if (run_q && !wrap_o) begin
                cnt_d = cnt_q + ONE;
            end
            tick_d  = (cnt_d == '0);
            // A new period is always high first: ratio_i may still be the
            // old (or zero) value on the edge that loads a new ratio, and
            // every legal ratio has floor(N/2) >= 1.
            phase_d = (cnt_d == '0) || (cnt_d < half);
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            cnt_q   <= '0;
            run_q   <= 1'b0;
            phase_q <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            run_q   <= run_i;
            phase_q <= phase_d;
            tick_q  <= tick_d;
        end
    end

    assign tick_o = tick_q;

`ifdef CLK_DIV_CTRL_ODD50_EN
    // Half-cycle extension of the high phase for odd ratios.
    logic phase_n_q;

    always_ff @(negedge clk_in) begin
        if (rst) begin
            phase_n_q <= 1'b0;
        end else begin
            phase_n_q <= phase_q & ratio_i[0];
        end
    end

    assign clk_out_o = phase_q | phase_n_q;
`else
    assign clk_out_o = phase_q;
`endif

endmodule

// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: programmable clock divider with a ready/valid ratio port.
// New ratios are accepted in IDLE/RUN; in RUN they are held until the
// current period ends so clk_out never glitches. Dropping en drains the
// current period before stopping.
//
// Ports:
//   clk_in       - system clock
//   rst          - synchronous active-high reset
//   en           - run request (level)
//   cfg_div      - requested divide ratio
//   cfg_valid    - cfg_div valid
//   cfg_ready    - ratio accepted this cycle when valid
//   cfg_err      - one-cycle pulse after an accepted ratio below 2
//   clk_out      - divided clock
//   tick         - first cycle of each clk_out period
//   ratio_active - ratio driving clk_out (0 = none loaded)
//
// Macro CLK_DIV_CTRL_ODD50_EN: enables 50% duty for odd ratios (in the core).
module clk_div_ctrl
    import clk_div_pkg::*;
#(
    parameter int unsigned RATIO_W = RATIO_W_DEF
) (
    input  logic               clk_in,
    input  logic               rst,
    input  logic               en,
    input  logic [RATIO_W-1:0] cfg_div,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    output logic               cfg_err,
    output logic               clk_out,
    output logic               tick,
    output logic [RATIO_W-1:0] ratio_active
);

    localparam logic [RATIO_W-1:0] MIN_R = RATIO_W'(MIN_RATIO);

    state_e             state_q, state_d;
    logic [RATIO_W-1:0] ratio_q, ratio_d;
    logic [RATIO_W-1:0] pend_q, pend_d;     // nonzero means a ratio is pending
    logic               err_q, err_d;
    logic               run_d;
    logic               wrap;
    logic               accept;
    logic               cfg_ok;

    assign cfg_ready = (state_q == IDLE) || (state_q == RUN);
    assign accept    = cfg_valid && cfg_ready;
    assign cfg_ok    = (cfg_div >= MIN_R);

    always_comb begin
        state_d = state_q;
        ratio_d = ratio_q;
        pend_d  = pend_q;
        err_d   = accept && !cfg_ok;
        run_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept && cfg_ok) begin
                    ratio_d = cfg_div;
                end
                if (en && (ratio_d >= MIN_R)) begin
                    state_d = RUN;
                    run_d   = 1'b1;
                end
            end
            RUN: begin
                run_d = 1'b1;
                if (accept && cfg_ok) begin
                    pend_d  = cfg_div;
                    state_d = PEND;
                end
                if (!en) begin
                    state_d = DRAIN;
                end
            end
            PEND: begin
                run_d = 1'b1;
                if (wrap) begin
                    ratio_d = pend_q;
                    pend_d  = '0;
                    state_d = RUN;
                end
                if (!en) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                run_d = 1'b1;
                if (wrap) begin
                    if (pend_q != '0) begin
                        ratio_d = pend_q;
                        pend_d  = '0;
                    end
                    state_d = IDLE;
                    run_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q <= IDLE;
            ratio_q <= '0;
            pend_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ratio_q <= ratio_d;
            pend_q  <= pend_d;
            err_q   <= err_d;
        end
    end

    assign cfg_err      = err_q;
    assign ratio_active = ratio_q;

    clk_div_core #(
        .RATIO_W (RATIO_W)
    ) u_core (
        .clk_in    (clk_in),
        .rst       (rst),
        .run_i     (run_d),
        .ratio_i   (ratio_q),
        .wrap_o    (wrap),
        .clk_out_o (clk_out),
        .tick_o    (tick)
    );

endmodule
